hazard_sched: RTL and testbench

//  Pipeline hazard scheduler: sequences the enables and flushes of the PC, IF_ID, ID_EX and EX_MEM registers.

---
 rtl/hazard_sched_pkg.sv | 14 +
 rtl/hazard_cmp.sv | 23 ++
 rtl/hazard_sched.sv | 152 +++++++++++++++
 tb/tb_hazard_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sched_pkg.sv
// Shared state encodings and constants for the pipeline hazard scheduler.
package hazard_sched_pkg;

    localparam int RREG_ADDR_BUS = 3;

    typedef enum logic [1:0] {
        HS_RUN      = 2'd0,
        HS_MEM_WAIT = 2'd1,
        HS_FLUSH    = 2'd2
    } hs_state_t;

    localparam logic [1:0] JP_NONE = 2'b00;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use comparator: the ID instruction reads the register a load in EX is about to write.
module hazard_cmp #(
    parameter int ADDR_W = 3
) (
    input  logic [ADDR_W-1:0] rs_addr_ID,
    input  logic              rs_used_ID,
    input  logic [ADDR_W-1:0] rt_addr_ID,
    input  logic              rt_used_ID,
    input  logic              read_mem_EX,
    input  logic              wite_reg_EX,
    input  logic [ADDR_W-1:0] addr3_EX,
    output logic              load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    // Register 0 is an ordinary register here, so no zero-address exclusion.
    assign w_rs_hit = rs_used_ID && (rs_addr_ID == addr3_EX);
    assign w_rt_hit = rt_used_ID && (rt_addr_ID == addr3_EX);
    assign load_use = read_mem_EX && wite_reg_EX && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler: drives PC/IF_ID/ID_EX/EX_MEM enables, flushes and bubbles
// for memory waits, taken jumps resolved in EX and load-use hazards.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int ADDR_W   = RREG_ADDR_BUS,
    parameter int BR_FLUSH = 1,
    parameter int MEM_TMO  = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr_ID,
    input  logic              rs_used_ID,
    input  logic [ADDR_W-1:0] rt_addr_ID,
    input  logic              rt_used_ID,
    input  logic              read_mem_EX,
    input  logic              wite_reg_EX,
    input  logic [ADDR_W-1:0] addr3_EX,
    input  logic [1:0]        jp_flag_EX,
    input  logic              mem_req_MEM,
    input  logic              mem_ack,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              ex_mem_en,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              mem_tmo
);

    localparam int         TMO_W      = $clog2(MEM_TMO + 1);
    localparam bit         HAS_FLUSH  = (BR_FLUSH > 0);
    localparam logic [1:0] FLUSH_LOAD = HAS_FLUSH ? 2'(BR_FLUSH - 1) : 2'd0;

    hs_state_t          r_state;
    logic [1:0]         r_flush_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_mem_tmo;

    logic w_load_use;
    logic w_redirect;
    logic w_mem_stall;
    logic w_stall;

    hazard_cmp #(.ADDR_W(ADDR_W)) u_cmp (
        .rs_addr_ID  (rs_addr_ID),
        .rs_used_ID  (rs_used_ID),
        .rt_addr_ID  (rt_addr_ID),
        .rt_used_ID  (rt_used_ID),
        .read_mem_EX (read_mem_EX),
        .wite_reg_EX (wite_reg_EX),
        .addr3_EX    (addr3_EX),
        .load_use    (w_load_use)
    );

    assign w_redirect  = (jp_flag_EX != JP_NONE);
    assign w_mem_stall = mem_req_MEM && !mem_ack;

    // Mealy decode; reset forces the safe values combinationally so they appear asynchronously.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_en    = 1'b1;
        if (!reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_en    = 1'b0;
        end else begin
            case (r_state)
                HS_RUN: begin
                    if (w_mem_stall) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        ex_mem_en = 1'b0;
                    end else if (w_redirect) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                HS_MEM_WAIT: begin
                    if (!mem_ack) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        ex_mem_en = 1'b0;
                    end
                end
                HS_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_stall = !pc_en || if_id_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= HS_RUN;
            r_flush_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_stall_cnt <= '0;
            r_mem_tmo   <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            case (r_state)
                HS_RUN: begin
                    if (w_mem_stall) begin
                        r_state   <= HS_MEM_WAIT;
                        r_tmo_cnt <= '0;
                    end else if (w_redirect && HAS_FLUSH) begin
                        r_state     <= HS_FLUSH;
                        r_flush_cnt <= FLUSH_LOAD;
                    end
                end
                HS_MEM_WAIT: begin
                    if (mem_ack) begin
                        r_state <= HS_RUN;
                    end else begin
                        if (r_tmo_cnt != TMO_W'(MEM_TMO))
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        if (r_tmo_cnt == TMO_W'(MEM_TMO - 1))
                            r_mem_tmo <= 1'b1;
                    end
                end
                HS_FLUSH: begin
                    if (r_flush_cnt == 2'd0)
                        r_state <= HS_RUN;
                    else
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                end
                default: r_state <= HS_RUN;
            endcase
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign mem_tmo   = r_mem_tmo;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched; a narrow-counter twin shares the stimulus to reach saturation.
module tb_hazard_sched;

    logic        clk;
    logic        reset;
    logic [2:0]  rs_addr_ID, rt_addr_ID, addr3_EX;
    logic        rs_used_ID, rt_used_ID, read_mem_EX, wite_reg_EX;
    logic [1:0]  jp_flag_EX;
    logic        mem_req_MEM, mem_ack;
    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_en, mem_tmo;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_bubble, s_ex_mem_en, s_mem_tmo;
    logic [3:0]  s_stall_cnt;

    int errors = 0;
    int checks = 0;

    hazard_sched #(.ADDR_W(3), .BR_FLUSH(1), .MEM_TMO(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rs_addr_ID(rs_addr_ID), .rs_used_ID(rs_used_ID),
        .rt_addr_ID(rt_addr_ID), .rt_used_ID(rt_used_ID),
        .read_mem_EX(read_mem_EX), .wite_reg_EX(wite_reg_EX), .addr3_EX(addr3_EX),
        .jp_flag_EX(jp_flag_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .ex_mem_en(ex_mem_en),
        .stall_cnt(stall_cnt), .mem_tmo(mem_tmo)
    );

    hazard_sched #(.ADDR_W(3), .BR_FLUSH(1), .MEM_TMO(15), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .rs_addr_ID(rs_addr_ID), .rs_used_ID(rs_used_ID),
        .rt_addr_ID(rt_addr_ID), .rt_used_ID(rt_used_ID),
        .read_mem_EX(read_mem_EX), .wite_reg_EX(wite_reg_EX), .addr3_EX(addr3_EX),
        .jp_flag_EX(jp_flag_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
        .id_ex_bubble(s_id_ex_bubble), .ex_mem_en(s_ex_mem_en),
        .stall_cnt(s_stall_cnt), .mem_tmo(s_mem_tmo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        rs_addr_ID = '0; rt_addr_ID = '0; addr3_EX = '0;
        rs_used_ID = 0; rt_used_ID = 0; read_mem_EX = 0; wite_reg_EX = 0;
        jp_flag_EX = 2'b00; mem_req_MEM = 0; mem_ack = 0;
    endtask

    initial begin
        idle();
        reset = 1'b0;

        // Reset held for 3 cycles
        repeat (3) tick();
        settle();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_if_id_en", if_id_en, 0);
        chk("rst_flush", if_id_flush, 1);
        chk("rst_bubble", id_ex_bubble, 1);
        chk("rst_ex_mem_en", ex_mem_en, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_mem_tmo", mem_tmo, 0);
        tick();
        reset = 1'b1;
        settle();
        chk("rel_pc_en", pc_en, 1);
        chk("rel_bubble", id_ex_bubble, 0);
        chk("rel_flush", if_id_flush, 0);
        chk("rel_stall_cnt", stall_cnt, 0);

        // Load-use on rs
        tick();
        read_mem_EX = 1; wite_reg_EX = 1; addr3_EX = 3'd3; rs_addr_ID = 3'd3; rs_used_ID = 1;
        settle();
        chk("lu_pc_en", pc_en, 0);
        chk("lu_if_id_en", if_id_en, 0);
        chk("lu_bubble", id_ex_bubble, 1);
        chk("lu_ex_mem_en", ex_mem_en, 1);
        tick();
        idle();
        settle();
        chk("lu_after_pc_en", pc_en, 1);
        chk("lu_after_bubble", id_ex_bubble, 0);
        chk("lu_after_stall_cnt", stall_cnt, 1);

        // Load-use on rt via register 0
        tick();
        read_mem_EX = 1; wite_reg_EX = 1; addr3_EX = 3'd0; rt_addr_ID = 3'd0; rt_used_ID = 1;
        settle();
        chk("lu0_pc_en", pc_en, 0);
        chk("lu0_bubble", id_ex_bubble, 1);
        tick();
        idle();

        // Same load, rs unused and rt different: no stall
        read_mem_EX = 1; wite_reg_EX = 1; addr3_EX = 3'd3;
        rs_addr_ID = 3'd3; rs_used_ID = 0; rt_addr_ID = 3'd2; rt_used_ID = 1;
        settle();
        chk("nolu_pc_en", pc_en, 1);
        chk("nolu_bubble", id_ex_bubble, 0);
        tick();
        idle();
        settle();
        chk("nolu_stall_cnt", stall_cnt, 2);

        // Taken jump with simultaneous load-use: two flush cycles, load-use squashed
        tick();
        jp_flag_EX = 2'b01;
        read_mem_EX = 1; wite_reg_EX = 1; addr3_EX = 3'd3; rs_addr_ID = 3'd3; rs_used_ID = 1;
        settle();
        chk("jp0_flush", if_id_flush, 1);
        chk("jp0_bubble", id_ex_bubble, 1);
        chk("jp0_pc_en", pc_en, 1);
        chk("jp0_if_id_en", if_id_en, 1);
        tick();
        idle();
        mem_req_MEM = 1;
        settle();
        chk("jp1_flush", if_id_flush, 1);
        chk("jp1_bubble", id_ex_bubble, 1);
        chk("jp1_pc_en", pc_en, 1);
        tick();
        idle();
        settle();
        chk("jp2_flush", if_id_flush, 0);
        chk("jp2_bubble", id_ex_bubble, 0);
        chk("jp2_pc_en", pc_en, 1);
        chk("jp2_stall_cnt", stall_cnt, 4);

        // Memory access acknowledged on the 4th cycle
        tick();
        mem_req_MEM = 1;
        settle();
        chk("m4_req_pc_en", pc_en, 0);
        chk("m4_req_ex_mem_en", ex_mem_en, 0);
        chk("m4_req_bubble", id_ex_bubble, 0);
        tick();
        mem_req_MEM = 0;
        for (int i = 1; i < 4; i++) begin
            settle();
            chk("m4_wait_pc_en", pc_en, 0);
            chk("m4_wait_if_id_en", if_id_en, 0);
            chk("m4_wait_ex_mem_en", ex_mem_en, 0);
            tick();
        end
        mem_ack = 1;
        settle();
        chk("m4_ack_pc_en", pc_en, 1);
        chk("m4_ack_if_id_en", if_id_en, 1);
        chk("m4_ack_ex_mem_en", ex_mem_en, 1);
        tick();
        mem_ack = 0;
        settle();
        chk("m4_done_pc_en", pc_en, 1);
        chk("m4_done_mem_tmo", mem_tmo, 0);
        chk("m4_done_stall_cnt", stall_cnt, 8);
        chk("m4_sat_stall_cnt", s_stall_cnt, 8);

        // Memory access acknowledged on the 20th cycle: timeout flagged and sticky
        tick();
        mem_req_MEM = 1;
        tick();
        mem_req_MEM = 0;
        for (int i = 1; i < 20; i++) begin
            settle();
            chk("m20_wait_pc_en", pc_en, 0);
            if (i == 5) chk("m20_early_tmo", mem_tmo, 0);
            tick();
        end
        settle();
        chk("m20_pre_ack_tmo", mem_tmo, 1);
        mem_ack = 1;
        settle();
        chk("m20_ack_pc_en", pc_en, 1);
        tick();
        mem_ack = 0;
        settle();
        chk("m20_run_pc_en", pc_en, 1);
        chk("m20_run_mem_tmo", mem_tmo, 1);
        chk("m20_stall_cnt", stall_cnt, 28);
        chk("sat_stall_cnt", s_stall_cnt, 4'hF);
        tick();
        settle();
        chk("sat_hold_stall_cnt", s_stall_cnt, 4'hF);
        chk("tmo_sticky", mem_tmo, 1);

        // Asynchronous reset during MEM_WAIT
        tick();
        mem_req_MEM = 1;
        tick();
        mem_req_MEM = 0;
        settle();
        chk("ar_wait_pc_en", pc_en, 0);
        #1 reset = 1'b0;
        #1;
        chk("ar_pc_en", pc_en, 0);
        chk("ar_if_id_en", if_id_en, 0);
        chk("ar_flush", if_id_flush, 1);
        chk("ar_bubble", id_ex_bubble, 1);
        chk("ar_ex_mem_en", ex_mem_en, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
        chk("ar_mem_tmo", mem_tmo, 0);
        chk("ar_sat_stall_cnt", s_stall_cnt, 0);
        tick();
        reset = 1'b1;
        settle();
        chk("ar_rel_pc_en", pc_en, 1);
        chk("ar_rel_ex_mem_en", ex_mem_en, 1);
        chk("ar_rel_bubble", id_ex_bubble, 0);
        tick();
        settle();
        chk("ar_rel_stall_cnt", stall_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
